serial_right_shifter: RTL
=========================

Name: serial_right_shifter

Overview:
Iterative, multi-cycle right-shift/rotate unit with valid/ready handshakes on both sides. It is the sequential, right-direction counterpart of the team's combinational barrel shifting. It moves one bit position per clock, trading latency for area. It sits between a producer issuing (data, amount, mode) commands and a consumer taking the shifted result.

Parameters:
DWIDTH, 8, data width in bits (≥2).
KWIDTH, 3, shift-amount width; equals $clog2(DWIDTH).

Ports:
i_clk  input  1  clock, all state updates on the rising edge.
i_rstn  input  1  asynchronous, active-low reset.
i_valid  input  1  command valid.
o_ready  output  1  block can accept a command.
i_data  input  DWIDTH  operand.
i_k  input  KWIDTH  shift amount, 0..DWIDTH-1.
i_mode  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 treated as 00.
o_valid  output  1  result valid.
i_ready  input  1  consumer accepts the result.
o_data  output  DWIDTH  shifted result.

Behaviour:
- Interface fixed: one clock, i_clk; reset i_rstn is asynchronous and active-low.
- Reset: state=IDLE, data reg=0, count=0, mode=00. Outputs: o_ready=1 (once reset is released), o_valid=0, o_data=0.
- Reset mid-operation: the in-flight command is discarded with no output. No o_valid pulse is emitted after release.
- FSM states: IDLE, SHIFT, DONE. o_ready=(state==IDLE). o_valid=(state==DONE). o_data is driven from the data register at all times.
- IDLE: on i_valid&&o_ready, latch i_data, i_k and i_mode (accept edge).
  - If i_k==0, go to DONE.
  - Otherwise go to SHIFT with count=i_k.
- SHIFT: each edge performs a 1-bit right step on the data register and decrements count.
  - When count==1 at the edge, go to DONE.
- Step rules for the 1-bit right step:
  - Logical: the new MSB is 0.
  - Arithmetic: the new MSB equals the current MSB.
  - Rotate: the new MSB equals the current LSB.
  - Mode 11 behaves as logical.
- DONE: hold o_data and o_valid stable until i_ready. On o_valid&&i_ready, go to IDLE. The data register keeps its value in IDLE.
- Latency: accept in cycle N gives o_valid high in cycle N+1+k.
- Throughput: at most one command per k+2 cycles. There is no accept in the same cycle as the output handshake.
- i_valid while not ready: ignored. The producer must hold the command until o_ready is seen high.
- Inputs are sampled only at the accept edge. Changes to i_data, i_k or i_mode during SHIFT or DONE have no effect.
- i_k width: KWIDTH bits, so k ≤ DWIDTH-1. No saturation logic is needed.
- Count is an unsigned KWIDTH-bit register and never wraps below 0.

Decomposition:
- Shared package (include file) holds:
  - mode constants MODE_LSR=2'b00, MODE_ASR=2'b01, MODE_ROR=2'b10;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One natural combinational sub-module, shift_step_r (DWIDTH param; inputs data and mode; output data stepped by one). It is instantiated once in the datapath and unit-testable on its own.
- FSM and count stay in the top module.

Test Plan:
1. i_data=8'hB4, i_k=3, mode=00, i_ready=1, accepted cycle N -> o_valid in cycle N+4, o_data=8'h16, then o_ready=1 next cycle.
2. i_data=8'hB4, i_k=3, mode=01 -> o_data=8'hF6 in cycle N+4. Repeat with mode=11 -> 8'h16.
3. i_data=8'hB4, i_k=3, mode=10 -> 8'h96. Also i_data=8'h81, i_k=7, mode=10 -> 8'h03 in cycle N+8.
4. i_data=8'h5A, i_k=0, mode=10 -> o_valid in cycle N+1 with o_data=8'h5A.
5. Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid and o_data stay stable and o_ready=0. A second command held on i_valid is accepted only in the first IDLE cycle after the handshake.
6. i_rstn pulsed low during SHIFT of an i_k=7 command -> o_valid=0, o_data=0 immediately (asynchronous). After release o_ready=1 and no o_valid until a new command completes.

Source files
------------

// File: rtl/serial_right_shifter_pkg.sv
// serial_right_shifter_pkg: shared mode constants and FSM state encodings
package serial_right_shifter_pkg;
  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;
endpackage

// File: rtl/serial_right_shifter_step.sv
// shift_step_r: one-bit right step; the mode only picks the bit entering the MSB
module shift_step_r
  import serial_right_shifter_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] i_data,
  input  logic [1:0]        i_mode,
  output logic [DWIDTH-1:0] o_data
);
  logic msb;
  // Unlisted mode 11 falls through to a zero fill, same as logical
  always_comb begin
    msb    = i_mode == MODE_ASR ? i_data[DWIDTH-1] : i_mode == MODE_ROR ? i_data[0] : 1'b0;
    o_data = {msb, i_data[DWIDTH-1:1]};
  end
endmodule

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle right shift/rotate, one bit per clock, valid/ready on both sides
module serial_right_shifter
  import serial_right_shifter_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int KWIDTH = $clog2(DWIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DWIDTH-1:0] i_data,
  input  logic [KWIDTH-1:0] i_k,
  input  logic [1:0]        i_mode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_data
);
  state_e            state_q, state_d;
  logic [DWIDTH-1:0] data_q, data_d, step;
  logic [KWIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  shift_step_r #(.DWIDTH(DWIDTH)) u_step (
    .i_data (data_q),
    .i_mode (mode_q),
    .o_data (step)
  );
  assign o_ready = state_q == ST_IDLE;
  assign o_valid = state_q == ST_DONE;
  assign o_data  = data_q;
  // Next state: latch the command on accept, step while counting down, hold the result until taken
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: if (i_valid) begin
        data_d  = i_data;
        cnt_d   = i_k;
        mode_d  = i_mode;
        state_d = i_k == '0 ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        data_d  = step;
        cnt_d   = cnt_q - KWIDTH'(1);
        state_d = cnt_q == KWIDTH'(1) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: state_d = i_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  // State registers; reset drops any in-flight command
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_LSR;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
endmodule
